// File: rtl/neuron_seq.sv
// Sequential neuron: one MAC per cycle into a saturating accumulator, then an
// activation lookup via external ROM. Define NEURON_RELU_EN to add a ReLU bypass.
module neuron_seq #(
  parameter int N_IN       = 7,
  parameter int DW         = 17,
  parameter int FRAC       = 16,
  parameter int ACC_W      = 24,
  parameter int LUT_AW     = 11,
  parameter int ADDR_SHIFT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N_IN*DW-1:0]   x,
  input  logic [N_IN*DW-1:0]   w,
  input  logic [DW-1:0]        bias,
`ifdef NEURON_RELU_EN
  input  logic                 relu_sel,
`endif
  output logic                 busy,
  output logic [LUT_AW-1:0]    lut_addr,
  input  logic [DW-1:0]        lut_data,
  output logic [DW-1:0]        y,
  output logic                 valid_out
);

  localparam int PW  = 2 * DW;
  localparam int SW  = ((ACC_W > PW) ? ACC_W : PW) + 1;
  localparam int AW2 = ((ACC_W > LUT_AW) ? ACC_W : LUT_AW) + 2;
  localparam int IW  = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic signed [SW-1:0] ACC_MAX =
    signed'({{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}});
  localparam logic signed [SW-1:0] ACC_MIN =
    signed'({{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}});
  localparam logic signed [AW2-1:0] ADDR_MID = AW2'(2 ** (LUT_AW - 1));
  localparam logic signed [AW2-1:0] ADDR_TOP = AW2'(2 ** LUT_AW - 1);

  typedef enum logic [2:0] {IDLE, MAC, ADDR, WAIT, DONE} state_t;

  state_t                   state;
  logic [N_IN*DW-1:0]       x_r;
  logic [N_IN*DW-1:0]       w_r;
  logic signed [ACC_W-1:0]  acc;
  logic [IW-1:0]            idx;

  logic signed [DW-1:0]     xe;
  logic signed [DW-1:0]     we;
  logic signed [PW-1:0]     prod;
  logic signed [SW-1:0]     sum;
  logic signed [ACC_W-1:0]  acc_sat;
  logic signed [ACC_W-1:0]  acc_sh;
  logic signed [AW2-1:0]    addr_s;
  logic [LUT_AW-1:0]        addr_c;

  always_comb begin
    xe   = x_r[idx*DW +: DW];
    we   = w_r[idx*DW +: DW];
    prod = xe * we;
    // Sum in a width that cannot overflow, then clamp into the accumulator range.
    sum  = SW'(acc) + SW'(prod >>> FRAC);
    if (sum > ACC_MAX)
      acc_sat = ACC_MAX[ACC_W-1:0];
    else if (sum < ACC_MIN)
      acc_sat = ACC_MIN[ACC_W-1:0];
    else
      acc_sat = sum[ACC_W-1:0];
  end

  always_comb begin
    acc_sh = acc >>> ADDR_SHIFT;
    addr_s = AW2'(acc_sh) + ADDR_MID;
    if (addr_s < 0)
      addr_c = '0;
    else if (addr_s > ADDR_TOP)
      addr_c = '1;
    else
      addr_c = addr_s[LUT_AW-1:0];
  end

`ifdef NEURON_RELU_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(2 ** (DW - 1) - 1);

  logic            relu_r;
  logic [DW-1:0]   relu_y;

  always_comb begin
    if (acc < 0)
      relu_y = '0;
    else if (acc > Y_MAX)
      relu_y = Y_MAX[DW-1:0];
    else
      relu_y = acc[DW-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      y         <= '0;
      lut_addr  <= '0;
      acc       <= '0;
      idx       <= '0;
      x_r       <= '0;
      w_r       <= '0;
`ifdef NEURON_RELU_EN
      relu_r    <= 1'b0;
`endif
    end else begin
      valid_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            x_r   <= x;
            w_r   <= w;
            acc   <= ACC_W'(signed'(bias));
            idx   <= '0;
            busy  <= 1'b1;
            state <= MAC;
`ifdef NEURON_RELU_EN
            relu_r <= relu_sel;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        MAC: begin
          acc <= acc_sat;
          idx <= idx + IW'(1);
          if (idx == IW'(N_IN - 1))
            state <= ADDR;
        end
        ADDR: begin
          lut_addr <= addr_c;
          state    <= WAIT;
        end
        WAIT: state <= DONE;
        DONE: begin
          // busy stays high through the valid_out cycle; IDLE drops it if no new start.
`ifdef NEURON_RELU_EN
          y <= relu_r ? relu_y : lut_data;
`else
          y <= lut_data;
`endif
          valid_out <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_seq.sv
// Bench for neuron_seq: directed corner vectors, random operations, back-to-back
// start stream and mid-operation reset, checked against an arithmetic model.
module tb_neuron_seq;

  localparam int N_IN       = 7;
  localparam int DW         = 17;
  localparam int FRAC       = 16;
  localparam int ACC_W      = 24;
  localparam int LUT_AW     = 11;
  localparam int ADDR_SHIFT = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [N_IN*DW-1:0]  x = '0;
  logic [N_IN*DW-1:0]  w = '0;
  logic [DW-1:0]       bias = '0;
  logic [DW-1:0]       lut_data = '0;
  logic                relu_sel = 1'b0;
  logic                busy;
  logic                valid_out;
  logic [LUT_AW-1:0]   lut_addr;
  logic [DW-1:0]       y;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  neuron_seq #(
    .N_IN(N_IN), .DW(DW), .FRAC(FRAC), .ACC_W(ACC_W),
    .LUT_AW(LUT_AW), .ADDR_SHIFT(ADDR_SHIFT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .x(x),
    .w(w),
    .bias(bias),
`ifdef NEURON_RELU_EN
    .relu_sel(relu_sel),
`endif
    .busy(busy),
    .lut_addr(lut_addr),
    .lut_data(lut_data),
    .y(y),
    .valid_out(valid_out)
  );

  function automatic logic [DW-1:0] rom_val(input longint a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E3779B1;
    return h[31 -: DW];
  endfunction

  // Synchronous activation ROM: data follows the address by one clock.
  always @(posedge clk) lut_data <= rom_val(longint'(lut_addr));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sx(input longint v);
    return (v >= (64'sd1 <<< (DW - 1))) ? v - (64'sd1 <<< DW) : v;
  endfunction

  function automatic void model(input logic [N_IN*DW-1:0] xv, input logic [N_IN*DW-1:0] wv,
                                input logic [DW-1:0] bv, input logic rs,
                                output longint acc, output longint addr, output longint yv);
    longint amax, p, ymax;
    amax = (64'sd1 <<< (ACC_W - 1)) - 1;
    ymax = (64'sd1 <<< (DW - 1)) - 1;
    acc  = sx(longint'(bv));
    for (int i = 0; i < N_IN; i++) begin
      p   = sx(longint'(xv[i*DW +: DW])) * sx(longint'(wv[i*DW +: DW]));
      acc = acc + (p >>> FRAC);
      if (acc > amax) acc = amax;
      if (acc < -amax - 1) acc = -amax - 1;
    end
    addr = (64'sd1 <<< (LUT_AW - 1)) + (acc >>> ADDR_SHIFT);
    if (addr < 0) addr = 0;
    if (addr > (64'sd1 <<< LUT_AW) - 1) addr = (64'sd1 <<< LUT_AW) - 1;
    if (rs)
      yv = (acc < 0) ? 0 : ((acc > ymax) ? ymax : acc);
    else
      yv = longint'(rom_val(addr));
  endfunction

  function automatic logic [DW-1:0] rand_elem();
    int r;
    r = int'($urandom);
    r = r >>> (15 + $urandom_range(0, 10));
    return DW'(r);
  endfunction

  function automatic logic [N_IN*DW-1:0] rand_vec();
    logic [N_IN*DW-1:0] v;
    for (int i = 0; i < N_IN; i++) v[i*DW +: DW] = rand_elem();
    return v;
  endfunction

  function automatic logic [N_IN*DW-1:0] fill_vec(input logic [DW-1:0] e);
    logic [N_IN*DW-1:0] v;
    for (int i = 0; i < N_IN; i++) v[i*DW +: DW] = e;
    return v;
  endfunction

  // Starts at a negedge with the DUT idle; returns at the negedge of the valid_out cycle.
  task automatic run_op(input string tag, input logic [N_IN*DW-1:0] xv,
                        input logic [N_IN*DW-1:0] wv, input logic [DW-1:0] bv,
                        input logic rs);
    longint ea, eaddr, ey;
    int k;
    model(xv, wv, bv, rs, ea, eaddr, ey);
    x = xv; w = wv; bias = bv; relu_sel = rs; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = rand_vec(); w = rand_vec(); bias = rand_elem(); relu_sel = ~rs;
    k = 1;
    while (k < 20) begin
      @(posedge clk); #1;
      if (valid_out) break;
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'd10);
    chk({tag, "_addr"}, 64'(lut_addr), 64'(eaddr));
    chk({tag, "_y"}, 64'(y), 64'(ey));
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    @(negedge clk);
  endtask

  task automatic stream_test();
    bit     ev[64];
    longint eyv[64];
    longint ea, eaddr, ey;
    int     free_at, pulses, last;
    logic [N_IN*DW-1:0] xv, wv;
    logic [DW-1:0] bv;
    for (int i = 0; i < 64; i++) begin ev[i] = 1'b0; eyv[i] = 0; end
    free_at = 0; pulses = 0; last = -1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      if (cyc < 30) begin
        xv = rand_vec(); wv = rand_vec(); bv = rand_elem();
        x = xv; w = wv; bias = bv; relu_sel = 1'b0; start = 1'b1;
        if (cyc >= free_at) begin
          model(xv, wv, bv, 1'b0, ea, eaddr, ey);
          ev[cyc + 10]  = 1'b1;
          eyv[cyc + 10] = ey;
          free_at = cyc + 11;
        end
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      chk("stream_valid", 64'(valid_out), 64'(ev[cyc]));
      if (ev[cyc]) chk("stream_y", 64'(y), 64'(eyv[cyc]));
      if (valid_out) begin
        pulses++;
        if (last >= 0) chk("stream_gap", 64'(cyc - last), 64'd11);
        last = cyc;
      end
      @(negedge clk);
    end
    chk("stream_pulses", 64'(pulses), 64'd3);
  endtask

  task automatic reset_test();
    x = rand_vec(); w = rand_vec(); bias = rand_elem(); relu_sel = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_addr", 64'(lut_addr), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      chk("rst_novalid", 64'(valid_out), 64'd0);
    end
    chk("rst_y_after", 64'(y), 64'd0);
    chk("rst_busy_after", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", rand_vec(), rand_vec(), rand_elem(), 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic rs;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(valid_out), 64'd0);
    chk("reset_y", 64'(y), 64'd0);
    chk("reset_addr", 64'(lut_addr), 64'd0);
    rst_n = 1'b1;

    run_op("half", fill_vec(17'h08000), fill_vec(17'h08000), '0, 1'b0);
    chk("half_addr_const", 64'(lut_addr), 64'd1472);
    chk("half_y_const", 64'(y), 64'(rom_val(1472)));
    run_op("neg1sq", fill_vec(17'h10000), fill_vec(17'h10000), '0, 1'b0);
    chk("neg1sq_addr_const", 64'(lut_addr), 64'd2047);
    run_op("neg1mul", fill_vec(17'h10000), fill_vec(17'h0FFFF), '0, 1'b0);
    chk("neg1mul_addr_const", 64'(lut_addr), 64'd0);

    for (int n = 0; n < 20; n++) begin
`ifdef NEURON_RELU_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op("rand", rand_vec(), rand_vec(), rand_elem(), rs);
    end

    stream_test();
    reset_test();

`ifdef NEURON_RELU_EN
    run_op("relu_neg", fill_vec(17'h10000), fill_vec(17'h0FFFF), '0, 1'b1);
    chk("relu_neg_const", 64'(y), 64'd0);
    run_op("relu_pos", fill_vec(17'h08000), fill_vec(17'h08000), '0, 1'b1);
    chk("relu_pos_const", 64'(y), 64'd65535);
    chk("relu_pos_addr_const", 64'(lut_addr), 64'd1472);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/neuron_seq.md
NEURON_SEQ -- requirements
Module: neuron_seq

Interface
REQ-001 Parameter N_IN, default 7: number of synaptic inputs, 1..64.
REQ-002 Parameter DW, default 17: signed two's-complement data width of x, w, bias and y.
REQ-003 Parameter FRAC, default 16: fractional bits of x, w, bias and the accumulator.
REQ-004 Parameter ACC_W, default 24: signed accumulator width, at least DW+clog2(N_IN+1).
REQ-005 Parameter LUT_AW, default 11: activation LUT address width.
REQ-006 Parameter ADDR_SHIFT, default 8: arithmetic right shift from accumulator to LUT offset.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 start  in  1  request pulse; sampled only while busy=0.
REQ-010 x  in  N_IN*DW  concatenated inputs; element i at bits [DW*(i+1)-1 : DW*i].
REQ-011 w  in  N_IN*DW  concatenated weights, same packing as x.
REQ-012 bias  in  DW  signed bias.
REQ-013 busy  out  1  high from the cycle after start acceptance through the valid_out cycle.
REQ-014 lut_addr  out  LUT_AW  registered address to the external activation ROM.
REQ-015 lut_data  in  DW  ROM output, valid one cycle after lut_addr changes.
REQ-016 y  out  DW  neuron output, held until the next result.
REQ-017 valid_out  out  1  one-cycle pulse marking a new y.

Function
REQ-018 FSM states IDLE, MAC, ADDR, WAIT, DONE; IDLE->MAC on start=1; MAC->ADDR after N_IN products; ADDR->WAIT->DONE->IDLE unconditionally.
REQ-019 On acceptance, x, w and bias are captured; acc is loaded with bias sign-extended to ACC_W; later input changes do not affect the result.
REQ-020 MAC adds one product per cycle, element 0 first: acc += (x[i]*w[i]) >>> FRAC, full 2*DW-bit signed product, floor rounding.
REQ-021 The accumulator saturates to the ACC_W signed range and never wraps.
REQ-022 In ADDR, lut_addr = 2^(LUT_AW-1) + (acc >>> ADDR_SHIFT), clamped to [0, 2^LUT_AW-1].
REQ-023 In DONE, y is loaded from lut_data and valid_out=1 for exactly that cycle.
REQ-024 Latency: valid_out is high in the cycle N_IN+3 edges after the edge that samples start.
REQ-025 start while busy=1 is ignored, not queued; start in the cycle after DONE is accepted, giving N_IN+4-cycle throughput.
REQ-026 lut_addr holds its last value outside ADDR.

Reset
REQ-027 rst_n=0 forces IDLE, busy=0, valid_out=0, y=0, lut_addr=0 and acc=0 immediately, regardless of clk.
REQ-028 Reset mid-operation discards the computation, with no valid_out.
REQ-029 After rst_n deasserts, the first start is accepted on the next rising edge.

Configuration
REQ-030 Macro NEURON_RELU_EN: when defined, input port relu_sel (1 bit) exists and is captured with start.
REQ-031 When captured relu_sel=1, y = acc clamped to [0, 2^(DW-1)-1]; lut_data is ignored; lut_addr and latency are unchanged.
REQ-032 When NEURON_RELU_EN is undefined, relu_sel is absent and behaviour is LUT-only, as above.

Verification (defaults: N_IN=7, DW=17, FRAC=16)
REQ-033 All x=w=0x08000 (0.5), bias=0, start -> lut_addr=1472 in ADDR, valid_out at start+10 edges, y=ROM[1472].
REQ-034 All x=w=0x10000 (-1.0), bias=0 -> acc=458752, lut_addr saturates to 2047.
REQ-035 All x=0x10000, w=0x0FFFF, bias=0 -> acc=-458745, lut_addr saturates to 0.
REQ-036 start pulsed every cycle for 30 cycles -> exactly 3 valid_out pulses, 11 cycles apart, each y correct for its captured operands.
REQ-037 rst_n low at MAC cycle 3, released 2 cycles later -> no valid_out, y=0, busy=0; next start gives a correct result.
REQ-038 With NEURON_RELU_EN, relu_sel=1 and the REQ-035 stimulus -> y=0; with the REQ-033 stimulus -> y=114688 clamped to 65535.
